// File: rtl/baud_gen_frac.sv
// Fractional baud generator: rx_tick every act_int(+carry) clocks, tx_tick every 16/8 rx_ticks.
// Registered strobes, first rx_tick act_int clocks after enable; no backpressure, free-running while enabled.
module baud_gen_frac #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [DIV_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  input  logic              i_osr_sel,
  output logic              rx_tick,
  output logic              tx_tick,
  output logic              o_cfg_err
);

  logic [DIV_W-1:0]  act_int;
  logic [FRAC_W-1:0] act_frac;
  logic              act_osr;
  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              carry;
  logic [3:0]        os_cnt;

  logic              cfg_bad;
  logic              run;
  logic [DIV_W:0]    last_cnt;
  logic [3:0]        os_last;
  logic              wrap;
  logic              bit_end;
  logic [FRAC_W:0]   acc_sum;

  assign cfg_bad  = (act_int < DIV_W'(2));
  assign run      = i_en && !cfg_bad;
  // P-1 computed one bit wider so act_int = 2^DIV_W-1 plus carry cannot overflow
  assign last_cnt = {1'b0, act_int} + {{DIV_W{1'b0}}, carry} - {{DIV_W{1'b0}}, 1'b1};
  assign os_last  = act_osr ? 4'd7 : 4'd15;
  assign wrap     = run && ({1'b0, cnt} == last_cnt);
  assign bit_end  = wrap && (os_cnt == os_last);
  assign acc_sum  = {1'b0, acc} + {1'b0, act_frac};

  // Shadows track the inputs while idle or misconfigured, otherwise only at period/bit boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_int  <= '0;
      act_frac <= '0;
      act_osr  <= 1'b0;
    end else if (!run) begin
      act_int  <= i_div_int;
      act_frac <= i_div_frac;
      act_osr  <= i_osr_sel;
    end else begin
      if (wrap) begin
        act_int  <= i_div_int;
        act_frac <= i_div_frac;
      end
      if (bit_end) begin
        act_osr <= i_osr_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      os_cnt  <= '0;
      rx_tick <= 1'b0;
      tx_tick <= 1'b0;
    end else if (!run) begin
      cnt     <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      os_cnt  <= '0;
      rx_tick <= 1'b0;
      tx_tick <= 1'b0;
    end else begin
      rx_tick <= wrap;
      tx_tick <= bit_end;
      if (wrap) begin
        cnt          <= '0;
        {carry, acc} <= acc_sum;
        os_cnt       <= (os_cnt == os_last) ? 4'd0 : os_cnt + 4'd1;
      end else begin
        cnt <= cnt + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cfg_err <= 1'b1;
    end else begin
      o_cfg_err <= cfg_bad;
    end
  end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed + randomized bench for baud_gen_frac; periods measured in clock edges between rx_tick pulses.
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_en;
  logic [15:0] i_div_int;
  logic [3:0]  i_div_frac;
  logic        i_osr_sel;
  logic        rx_tick;
  logic        tx_tick;
  logic        o_cfg_err;

  int checks   = 0;
  int failures = 0;
  int stray    = 0;

  baud_gen_frac #(.DIV_W(16), .FRAC_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (i_en),
    .i_div_int  (i_div_int),
    .i_div_frac (i_div_frac),
    .i_osr_sel  (i_osr_sel),
    .rx_tick    (rx_tick),
    .tx_tick    (tx_tick),
    .o_cfg_err  (o_cfg_err)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Edges until rx_tick is seen high (sampled 1 time unit after each edge); -1 on timeout
  task automatic wait_rx(input int max_edges, output int n);
    n = -1;
    for (int i = 1; i <= max_edges; i++) begin
      @(posedge clk);
      #1;
      if (tx_tick && !rx_tick) stray++;
      if (rx_tick) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic step(input int edges);
    repeat (edges) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clean start: configure while idle, then enable; first tick lands d edges later
  task automatic start(input int d, input int f, input logic osr);
    int n;
    i_en       = 1'b0;
    i_div_int  = 16'(d);
    i_div_frac = 4'(f);
    i_osr_sel  = osr;
    step(2);
    i_en = 1'b1;
    wait_rx(d + 5, n);
    check("first_tick", n, d);
  endtask

  // Period k (k>=2) of a constant divisor d+f/16 with the accumulator starting at zero
  function automatic int ref_period(input int d, input int f, input int k);
    return d + ((k - 1) * f) / 16 - ((k - 2) * f) / 16;
  endfunction

  initial begin
    int n;
    int bad;
    int span;
    int next_tx;
    int d;
    int f;

    rst_n      = 1'b0;
    i_en       = 1'b1;
    i_div_int  = 16'd325;
    i_div_frac = 4'd0;
    i_osr_sel  = 1'b0;

    // 200 ns of reset: strobes quiet, config error flagged
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst_rx", int'(rx_tick), 0);
      check("rst_tx", int'(tx_tick), 0);
      check("rst_err", int'(o_cfg_err), 1);
    end
    rst_n = 1'b1;
    // one edge loads the shadow from its zero reset value, then 325 edges of counting
    wait_rx(400, n);
    check("rst_first", n, 326);
    check("rst_err_clr", int'(o_cfg_err), 0);
    for (int i = 0; i < 3; i++) begin
      wait_rx(400, n);
      check("int325", n, 325);
    end

    start(27, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      wait_rx(40, n);
      check("int27", n, 27);
    end

    start(2, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      wait_rx(10, n);
      check("int2", n, 2);
    end

    // 27 + 2/16: one 28-clock period in every eight
    start(27, 2, 1'b0);
    span = 0;
    for (int k = 2; k <= 17; k++) begin
      wait_rx(40, n);
      check("frac_period", n, ref_period(27, 2, k));
      span += n;
      if (k == 9 || k == 17) begin
        check("frac_span8", span, 8 * 27 + (8 * 2) / 16);
        span = 0;
      end
    end

    // Ratio switch mid-bit: the bit in progress keeps 16, later bits use 8
    start(100, 0, 1'b0);
    next_tx = 16;
    check("osr_tx1", int'(tx_tick), 0);
    for (int k = 2; k <= 48; k++) begin
      wait_rx(120, n);
      check("osr_spacing", n, 100);
      if (k == next_tx) begin
        check("osr_tx_on", int'(tx_tick), 1);
        next_tx += i_osr_sel ? 8 : 16;
      end else begin
        check("osr_tx_off", int'(tx_tick), 0);
      end
      if (k == 20) i_osr_sel = 1'b1;
    end

    // Divisor change 30 clocks into a period takes effect only at the next boundary
    start(100, 0, 1'b0);
    wait_rx(120, n);
    check("dyn_pre", n, 100);
    step(30);
    i_div_int = 16'd50;
    wait_rx(120, n);
    check("dyn_cur", n + 30, 100);
    for (int i = 0; i < 2; i++) begin
      wait_rx(120, n);
      check("dyn_new", n, 50);
    end

    // Invalid divisors: no strobes, error held
    for (int v = 1; v >= 0; v--) begin
      i_en      = 1'b0;
      i_div_int = 16'(v);
      step(2);
      i_en = 1'b1;
      bad  = 0;
      for (int i = 0; i < 1000; i++) begin
        @(posedge clk);
        #1;
        if (rx_tick || tx_tick || !o_cfg_err) bad++;
      end
      check("cfg_err_quiet", bad, 0);
    end
    // Valid divisor while enabled: one edge to load, then a fresh first period
    i_div_int = 16'd40;
    wait_rx(100, n);
    check("cfg_recover", n, 41);
    check("cfg_err_clr", int'(o_cfg_err), 0);

    // Reset asserted on a tick cycle clears the outputs immediately
    i_div_int = 16'd60;
    wait_rx(100, n);
    check("pre_rst", n, 40);
    rst_n = 1'b0;
    #2;
    check("async_rx", int'(rx_tick), 0);
    check("async_tx", int'(tx_tick), 0);
    check("async_err", int'(o_cfg_err), 1);
    #5;
    rst_n = 1'b1;
    wait_rx(100, n);
    check("post_rst", n, 61);

    // One-cycle enable pulse restarts the phase
    step(20);
    i_en = 1'b0;
    step(1);
    check("pulse_rx", int'(rx_tick), 0);
    i_en = 1'b1;
    wait_rx(100, n);
    check("pulse_restart", n, 60);

    // Random divisors against the arithmetic period model
    for (int it = 0; it < 20; it++) begin
      d = $urandom_range(250, 10);
      f = $urandom_range(15, 0);
      start(d, f, 1'b0);
      span = 0;
      for (int k = 2; k <= 17; k++) begin
        wait_rx(d + 5, n);
        check("rnd_period", n, ref_period(d, f, k));
        span += n;
      end
      check("rnd_span16", span, 16 * d + (16 * f) / 16);
    end

    check("stray_tx", stray, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
